stopwatch_lap_ctl: RTL and testbench
====================================

// Module: stopwatch_lap_ctl
// PURPOSE
//  Parametrised successor of the stopwatch control FSM. Decodes debounced one-cycle trig/split
//  button pulses into counter controls (init_regs, count_enabled), adds split-hold (display
//  frozen while counting continues) and a lap recorder emitting write strobes into an external
//  LAP_DEPTH-entry lap-time RAM. Sits between the button debouncers and Counter/display path.
// PARAMETERS
//  LAP_DEPTH     8      number of lap slots (>=2); LAP_W = $clog2(LAP_DEPTH), lap_count width LAP_W+1
//  LAP_WRAP      0      0: saturate when full, drop further laps; 1: wrap index, overwrite oldest
//  IDLE_TIMEOUT  1000   PAUSED cycles before auto-return to IDLE (only with STOPWATCH_AUTOIDLE_EN)
// PORTS
//  clk            in   1        system clock, all logic on rising edge
//  reset          in   1        synchronous, active-high; overrides all other inputs
//  trig           in   1        start/stop pulse (one cycle, debounced)
//  split          in   1        split/lap/clear pulse (one cycle, debounced)
//  init_regs      out  1        clear counter registers (combinational decode)
//  count_enabled  out  1        counter advances this cycle
//  display_hold   out  1        display shows latched value, counter keeps running
//  lap_wr         out  1        one-cycle strobe: write current time to lap RAM at lap_idx
//  lap_idx        out  LAP_W    lap RAM address for lap_wr
//  lap_count      out  LAP_W+1  laps recorded since last clear (saturates at LAP_DEPTH)
//  lap_full       out  1        lap_count == LAP_DEPTH
// BEHAVIOUR
//  - One-hot states IDLE, COUNTING, SPLIT, PAUSED; illegal encoding -> IDLE next cycle.
//  - reset=1 at a clk edge: state=IDLE, lap_count=0, lap_idx=0, lap_wr=0, display_hold=0, timeout
//    counter=0; any lap_wr that would have issued that cycle is suppressed.
//  - trig has priority over split whenever both are high in the same cycle.
//  - IDLE: trig -> COUNTING; split ignored. init_regs = (state==IDLE) && !trig.
//  - COUNTING: trig -> PAUSED; split -> SPLIT and record a lap.
//  - SPLIT: trig -> PAUSED (hold released); split -> COUNTING (hold released, no lap recorded).
//  - PAUSED: trig -> COUNTING; split -> IDLE, clears lap_count/lap_idx to 0 same edge.
//  - count_enabled = state in {COUNTING, SPLIT}; display_hold = (state==SPLIT); both registered
//    decode of state, so they change on the edge after the accepting pulse (1-cycle latency).
//  - Lap record: lap_wr=1 for exactly the cycle after split accepted in COUNTING, lap_idx = slot
//    written; lap_count increments on the same edge lap_wr rises.
//  - Full, LAP_WRAP=0: state still enters SPLIT, lap_wr stays 0, lap_count held at LAP_DEPTH.
//  - LAP_WRAP=1: lap_idx wraps LAP_DEPTH-1 -> 0, lap_wr always issued, lap_count saturates.
//  - lap_full registered alongside lap_count; clears on PAUSED->IDLE clear or reset.
// CONFIGURATION
//  STOPWATCH_AUTOIDLE_EN defined: counter runs while in PAUSED with no trig/split; on
//   IDLE_TIMEOUT-th consecutive PAUSED cycle state -> IDLE with lap clear as for split. Counter
//   zeroed on any PAUSED exit or input pulse. Pulse in the terminal cycle wins over timeout.
//  STOPWATCH_AUTOIDLE_EN undefined: no timeout counter; PAUSED held until trig/split/reset.
// TESTING
//  1. reset 2 cycles, trig@5 -> init_regs 1 until trig cycle, count_enabled=1 from cycle 6.
//  2. COUNTING, split@10 -> display_hold=1, lap_wr=1 only cycle 11 lap_idx=0, lap_count=1;
//     split@20 -> display_hold=0 from 21, no lap_wr.
//  3. LAP_DEPTH=4, LAP_WRAP=0: 5 laps -> lap_wr for first 4 only, lap_full=1, lap_count=4;
//     LAP_WRAP=1: 5th lap_wr with lap_idx=0.
//  4. trig and split high same cycle in COUNTING -> PAUSED, no lap_wr, display_hold=0.
//  5. PAUSED, split -> IDLE, lap_count=0, lap_full=0; reset asserted in SPLIT mid-lap_wr ->
//     lap_wr=0 and all outputs at reset values next cycle.
//  6. AUTOIDLE_EN, IDLE_TIMEOUT=16: PAUSED idle 16 cycles -> IDLE, laps cleared; trig at 15th
//     cycle -> COUNTING, laps kept.

Source files
------------

// File: rtl/stopwatch_lap_ctl.sv
// rtl/stopwatch_lap_ctl.sv - stopwatch start/stop/split control with lap recorder
// Optional PAUSED auto-idle timeout enabled by defining STOPWATCH_AUTOIDLE_EN.
module stopwatch_lap_ctl #(
    parameter int LAP_DEPTH    = 8,
    parameter int LAP_WRAP     = 0,
    parameter int IDLE_TIMEOUT = 1000,
    localparam int LAP_W       = $clog2(LAP_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig,
    input  logic             split,
    output logic             init_regs,
    output logic             count_enabled,
    output logic             display_hold,
    output logic             lap_wr,
    output logic [LAP_W-1:0] lap_idx,
    output logic [LAP_W:0]   lap_count,
    output logic             lap_full
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'b0001,
        S_COUNTING = 4'b0010,
        S_SPLIT    = 4'b0100,
        S_PAUSED   = 4'b1000
    } state_t;

    localparam logic [LAP_W:0]   DEPTH_C = (LAP_W + 1)'(LAP_DEPTH);
    localparam logic [LAP_W-1:0] LAST_C  = LAP_W'(LAP_DEPTH - 1);

    if (LAP_DEPTH < 2) begin : g_depth_chk
        $error("stopwatch_lap_ctl: LAP_DEPTH must be at least 2");
    end
    if (IDLE_TIMEOUT < 1) begin : g_tmo_chk
        $error("stopwatch_lap_ctl: IDLE_TIMEOUT must be at least 1");
    end

    state_t           state;
    state_t           next_state;
    logic             lap_req;
    logic             lap_clear;
    logic             lap_do;
    logic [LAP_W-1:0] wr_ptr;

`ifdef STOPWATCH_AUTOIDLE_EN
    localparam int TMO_W = $clog2(IDLE_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_next;
`endif

    assign init_regs = (state == S_IDLE) && !trig;

    always_comb begin
        next_state = S_IDLE;
        lap_req    = 1'b0;
        lap_clear  = 1'b0;
`ifdef STOPWATCH_AUTOIDLE_EN
        tmo_next   = '0;
`endif
        case (state)
            S_IDLE: begin
                next_state = trig ? S_COUNTING : S_IDLE;
            end
            S_COUNTING: begin
                if (trig) begin
                    next_state = S_PAUSED;
                end else if (split) begin
                    next_state = S_SPLIT;
                    lap_req    = 1'b1;
                end else begin
                    next_state = S_COUNTING;
                end
            end
            S_SPLIT: begin
                if (trig) begin
                    next_state = S_PAUSED;
                end else if (split) begin
                    next_state = S_COUNTING;
                end else begin
                    next_state = S_SPLIT;
                end
            end
            S_PAUSED: begin
                if (trig) begin
                    next_state = S_COUNTING;
                end else if (split) begin
                    next_state = S_IDLE;
                    lap_clear  = 1'b1;
                end else begin
`ifdef STOPWATCH_AUTOIDLE_EN
                    // tmo_cnt holds the number of quiet PAUSED cycles already elapsed
                    if (tmo_cnt == TMO_W'(IDLE_TIMEOUT - 1)) begin
                        next_state = S_IDLE;
                        lap_clear  = 1'b1;
                    end else begin
                        next_state = S_PAUSED;
                        tmo_next   = tmo_cnt + TMO_W'(1);
                    end
`else
                    next_state = S_PAUSED;
`endif
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Once full, a non-wrapping recorder still enters SPLIT but writes nothing
    assign lap_do = lap_req && ((lap_count != DEPTH_C) || (LAP_WRAP != 0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            count_enabled <= 1'b0;
            display_hold  <= 1'b0;
            lap_wr        <= 1'b0;
            lap_idx       <= '0;
            wr_ptr        <= '0;
            lap_count     <= '0;
            lap_full      <= 1'b0;
        end else begin
            state         <= next_state;
            count_enabled <= (next_state == S_COUNTING) || (next_state == S_SPLIT);
            display_hold  <= (next_state == S_SPLIT);
            lap_wr        <= lap_do;
            if (lap_clear) begin
                lap_idx   <= '0;
                wr_ptr    <= '0;
                lap_count <= '0;
                lap_full  <= 1'b0;
            end else if (lap_do) begin
                lap_idx <= wr_ptr;
                wr_ptr  <= (wr_ptr == LAST_C) ? '0 : wr_ptr + LAP_W'(1);
                if (lap_count != DEPTH_C) begin
                    lap_count <= lap_count + (LAP_W + 1)'(1);
                    lap_full  <= (lap_count + (LAP_W + 1)'(1)) == DEPTH_C;
                end
            end
        end
    end

`ifdef STOPWATCH_AUTOIDLE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_next;
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_lap_ctl.sv
// tb/tb_stopwatch_lap_ctl.sv - self-checking bench, LAP_DEPTH=4 with and without wrap
module tb_stopwatch_lap_ctl;
    localparam int D  = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset, trig, split;
    logic       ir [2];
    logic       ce [2];
    logic       dh [2];
    logic       lw [2];
    logic [1:0] li [2];
    logic [2:0] lc [2];
    logic       lf [2];

    int compared = 0;
    int mismatched = 0;

    // reference model: 0 idle, 1 counting, 2 split, 3 paused
    int m_st = 0;
    int m_tmo = 0;
    int m_cnt [2];
    int m_slot [2];
    int m_idx [2];
    bit m_wr [2];
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    stopwatch_lap_ctl #(.LAP_DEPTH(D), .LAP_WRAP(0), .IDLE_TIMEOUT(TO)) u_sat (
        .clk(clk), .reset(reset), .trig(trig), .split(split),
        .init_regs(ir[0]), .count_enabled(ce[0]), .display_hold(dh[0]),
        .lap_wr(lw[0]), .lap_idx(li[0]), .lap_count(lc[0]), .lap_full(lf[0])
    );

    stopwatch_lap_ctl #(.LAP_DEPTH(D), .LAP_WRAP(1), .IDLE_TIMEOUT(TO)) u_wrap (
        .clk(clk), .reset(reset), .trig(trig), .split(split),
        .init_regs(ir[1]), .count_enabled(ce[1]), .display_hold(dh[1]),
        .lap_wr(lw[1]), .lap_idx(li[1]), .lap_count(lc[1]), .lap_full(lf[1])
    );

    task automatic chk(input string tag, input int w, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s wrap%0d observed=%0h expected=%0h", tag, w, obs, exp);
        end
    endtask

    task automatic clear_laps();
        for (int w = 0; w < 2; w++) begin
            m_cnt[w]  = 0;
            m_slot[w] = 0;
            m_idx[w]  = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit t, input bit s);
        reset = r;
        trig  = t;
        split = s;
        #1;
        if (m_valid) begin
            for (int w = 0; w < 2; w++) chk("init_regs", w, 32'(ir[w]), 32'(m_st == 0 && !t));
        end
        @(posedge clk);
        for (int w = 0; w < 2; w++) m_wr[w] = 1'b0;
        if (r) begin
            m_st  = 0;
            m_tmo = 0;
            clear_laps();
        end else begin
            case (m_st)
                0: if (t) m_st = 1;
                1: begin
                    if (t) m_st = 3;
                    else if (s) begin
                        m_st = 2;
                        for (int w = 0; w < 2; w++) begin
                            if (m_cnt[w] < D || w == 1) begin
                                m_wr[w]   = 1'b1;
                                m_idx[w]  = m_slot[w];
                                m_slot[w] = (m_slot[w] + 1) % D;
                            end
                            if (m_cnt[w] < D) m_cnt[w]++;
                        end
                    end
                end
                2: begin
                    if (t) m_st = 3;
                    else if (s) m_st = 1;
                end
                default: begin
                    if (t) m_st = 1;
                    else if (s) begin
                        m_st = 0;
                        clear_laps();
                    end else begin
`ifdef STOPWATCH_AUTOIDLE_EN
                        m_tmo++;
                        if (m_tmo == TO) begin
                            m_st = 0;
                            clear_laps();
                        end
`endif
                    end
                end
            endcase
            if (m_st != 3 || t || s) m_tmo = 0;
        end
        m_valid = 1'b1;
        #1;
        for (int w = 0; w < 2; w++) begin
            chk("count_enabled", w, 32'(ce[w]), 32'(m_st == 1 || m_st == 2));
            chk("display_hold", w, 32'(dh[w]), 32'(m_st == 2));
            chk("lap_wr", w, 32'(lw[w]), 32'(m_wr[w]));
            chk("lap_idx", w, 32'(li[w]), 32'(m_idx[w]));
            chk("lap_count", w, 32'(lc[w]), 32'(m_cnt[w]));
            chk("lap_full", w, 32'(lf[w]), 32'(m_cnt[w] == D));
        end
    endtask

    initial begin
        reset = 1'b1;
        trig  = 1'b0;
        split = 1'b0;
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("reset_count", 0, 32'(lc[0]), 32'd0);
        chk("reset_hold", 1, 32'(dh[1]), 32'd0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        chk("start_count_en", 0, 32'(ce[0]), 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        cycle(0, 0, 1);
        chk("first_lap_wr", 0, 32'(lw[0]), 32'd1);
        chk("first_lap_idx", 0, 32'(li[0]), 32'd0);
        cycle(0, 0, 0);
        chk("lap_wr_single", 0, 32'(lw[0]), 32'd0);
        cycle(0, 0, 1);
        chk("split_release", 0, 32'(dh[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1);
            cycle(0, 0, 1);
        end
        chk("sat_count", 0, 32'(lc[0]), 32'd4);
        chk("sat_full", 0, 32'(lf[0]), 32'd1);
        cycle(0, 0, 1);
        chk("sat_no_wr", 0, 32'(lw[0]), 32'd0);
        chk("wrap_wr", 1, 32'(lw[1]), 32'd1);
        chk("wrap_idx", 1, 32'(li[1]), 32'd1);
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        chk("both_pulse_wr", 0, 32'(lw[0]), 32'd0);
        chk("both_pulse_hold", 0, 32'(dh[0]), 32'd0);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        chk("clear_count", 0, 32'(lc[0]), 32'd0);
        chk("clear_full", 0, 32'(lf[0]), 32'd0);
        cycle(0, 1, 0);
        cycle(0, 0, 1);
        cycle(1, 0, 0);
        chk("reset_mid_lap", 0, 32'(lw[0]), 32'd0);
        cycle(0, 1, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 1, 0);
        for (int i = 0; i < TO + 2; i++) cycle(0, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        for (int i = 0; i < TO - 2; i++) cycle(0, 0, 0);
        cycle(0, 1, 0);
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
